// File: rtl/readout_dout_multi_if.sv
// readout_dout_multi_if: converted-word valid/ready stream toward the DIF readout FIFO
interface readout_dout_multi_if #(
  parameter int WORD_W = 16,
  parameter int CH_W = 1
);
  logic [WORD_W-1:0] Out_Data;
  logic [CH_W-1:0] Out_Ch;
  logic Out_Valid;
  logic In_Ready;
  modport master (output Out_Data, Out_Ch, Out_Valid, input In_Ready);
  modport slave (input Out_Data, Out_Ch, Out_Valid, output In_Ready);
endinterface

// File: rtl/readout_dout_multi.sv
// readout_dout_multi: multi-channel Doutb deserializer with Gray decode, per-channel buffering and round-robin merge
module readout_dout_multi #(
  parameter int NUM_CH = 2,
  parameter int WORD_W = 16,
  parameter int GRAY_W = 12,
  parameter int DIV = 4,
  parameter int SAMPLE_PHASE = 1,
  parameter int THRESH = 1580,
  parameter int CNT_W = 16
) (
  input logic Clk,
  input logic Rst,
  input logic [NUM_CH-1:0] In_Doutb,
  input logic [NUM_CH-1:0] In_TransmitOnb,
  readout_dout_multi_if.master bus,
  output logic [NUM_CH-1:0] Reach_Thresh,
  output logic [NUM_CH-1:0] Frame_End,
  output logic [NUM_CH-1:0] Overflow
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int PH_W = $clog2(DIV);
  localparam int BC_W = $clog2(WORD_W);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0] PH_SMP = PH_W'(SAMPLE_PHASE);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);
  logic [NUM_CH-1:0] tx_m, tx_s, tx_p, dout_m, dout_s, fin, done, ne, pop;
  logic [PH_W-1:0] phase [NUM_CH];
  logic [BC_W-1:0] bitc [NUM_CH];
  logic [WORD_W-1:0] sr [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [WORD_W-1:0] mem [NUM_CH][2];
  logic [NUM_CH-1:0] rp, wp;
  logic [1:0] fill [NUM_CH];
  logic [CH_W-1:0] ptr, gnt, j;
  logic any, load;
  function automatic logic [WORD_W-1:0] g2b(input logic [WORD_W-1:0] r);
    g2b = r;
    for (int i = GRAY_W - 2; i >= 0; i--) g2b[i] = g2b[i+1] ^ r[i];
  endfunction
  // two-flop synchronisers plus a delayed tx copy for frame edge detection
  always_ff @(posedge Clk)
    if (Rst) begin
      tx_m <= '1;
      tx_s <= '1;
      tx_p <= '1;
      dout_m <= '1;
      dout_s <= '1;
    end else begin
      tx_m <= In_TransmitOnb;
      tx_s <= tx_m;
      tx_p <= tx_s;
      dout_m <= In_Doutb;
      dout_s <= dout_m;
    end
  assign Frame_End = tx_s & ~tx_p;
  // word-complete strobe: last bit sampled this cycle
  always_comb begin
    fin = '0;
    for (int c = 0; c < NUM_CH; c++) fin[c] = !tx_s[c] && phase[c] == PH_SMP && bitc[c] == BC_LAST;
  end
  // per-channel bit timing and MSB-first shift register, idle while tx is high
  always_ff @(posedge Clk)
    for (int c = 0; c < NUM_CH; c++)
      if (Rst || tx_s[c]) begin
        phase[c] <= '0;
        bitc[c] <= '0;
        sr[c] <= '0;
        done[c] <= 1'b0;
      end else begin
        phase[c] <= phase[c] == PH_LAST ? '0 : phase[c] + PH_W'(1);
        done[c] <= fin[c];
        if (phase[c] == PH_SMP) begin
          sr[c] <= {sr[c][WORD_W-2:0], ~dout_s[c]};
          bitc[c] <= bitc[c] == BC_LAST ? '0 : bitc[c] + BC_W'(1);
        end
      end
  // per-frame word counters, cleared at frame start, saturating, held after frame end
  always_ff @(posedge Clk)
    for (int c = 0; c < NUM_CH; c++)
      if (Rst || (tx_p[c] && !tx_s[c])) cnt[c] <= '0;
      else if (fin[c] && cnt[c] != '1) cnt[c] <= cnt[c] + CNT_W'(1);
  // threshold flags straight from the counters
  always_comb begin
    Reach_Thresh = '0;
    for (int c = 0; c < NUM_CH; c++) Reach_Thresh[c] = cnt[c] >= CNT_W'(THRESH);
  end
  // two-entry channel FIFOs; a push into a full FIFO with no pop is dropped and flagged
  always_ff @(posedge Clk)
    for (int c = 0; c < NUM_CH; c++)
      if (Rst) begin
        rp[c] <= 1'b0;
        wp[c] <= 1'b0;
        fill[c] <= 2'd0;
        Overflow[c] <= 1'b0;
      end else begin
        if (done[c] && (fill[c] != 2'd2 || pop[c])) begin
          mem[c][wp[c]] <= g2b(sr[c]);
          wp[c] <= ~wp[c];
        end
        if (done[c] && fill[c] == 2'd2 && !pop[c]) Overflow[c] <= 1'b1;
        if (pop[c]) rp[c] <= ~rp[c];
        fill[c] <= fill[c] + 2'(done[c] && (fill[c] != 2'd2 || pop[c])) - 2'(pop[c]);
      end
  // round-robin grant: first non-empty channel after the last granted one
  always_comb begin
    ne = '0;
    for (int c = 0; c < NUM_CH; c++) ne[c] = fill[c] != 2'd0;
    gnt = ptr;
    any = 1'b0;
    j = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      j = CH_W'((int'(ptr) + k) % NUM_CH);
      if (ne[j]) begin
        any = 1'b1;
        gnt = j;
      end
    end
    load = !bus.Out_Valid || bus.In_Ready;
    pop = '0;
    if (load && any) pop[gnt] = 1'b1;
  end
  // output register, reloaded whenever empty or the current word is accepted
  always_ff @(posedge Clk)
    if (Rst) begin
      bus.Out_Valid <= 1'b0;
      bus.Out_Data <= '0;
      bus.Out_Ch <= '0;
      ptr <= '0;
    end else if (load) begin
      bus.Out_Valid <= any;
      if (any) begin
        bus.Out_Data <= mem[gnt][rp[gnt]];
        bus.Out_Ch <= gnt;
        ptr <= gnt;
      end
    end
endmodule

// File: tb/tb_readout_dout_multi.sv
// tb_readout_dout_multi: directed checks of the multi-channel Doutb deserializer
module tb_readout_dout_multi;
  localparam int DIV = 4;
  typedef struct {
    logic ch;
    logic [15:0] raw;
    logic [15:0] exp;
  } vec_t;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [1:0] In_Doutb = '1;
  logic [1:0] In_TransmitOnb = '1;
  logic [1:0] Reach_Thresh, Frame_End, Overflow;
  int passed = 0;
  int total = 0;
  readout_dout_multi_if #(.WORD_W(16), .CH_W(1)) bus ();
  readout_dout_multi #(.THRESH(3)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .In_Doutb(In_Doutb),
    .In_TransmitOnb(In_TransmitOnb),
    .bus(bus),
    .Reach_Thresh(Reach_Thresh),
    .Frame_End(Frame_End),
    .Overflow(Overflow)
  );
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic send(input logic [1:0] m, input logic [15:0] w0, input logic [15:0] w1, input int n);
    for (int k = 0; k < n; k++) begin
      if (m[0]) In_Doutb[0] = ~w0[15-k];
      if (m[1]) In_Doutb[1] = ~w1[15-k];
      repeat (DIV) tick();
    end
  endtask
  task automatic xfer(input logic ch, input logic [15:0] raw, input logic [15:0] exp, input string nm);
    In_TransmitOnb[ch] = 1'b0;
    send(ch ? 2'b10 : 2'b01, raw, raw, 16);
    chk({nm, "_rt"}, 32'(Reach_Thresh[ch]), 0);
    tick();
    chk({nm, "_early"}, 32'(bus.Out_Valid), 0);
    tick();
    chk({nm, "_valid"}, 32'(bus.Out_Valid), 1);
    chk({nm, "_data"}, 32'(bus.Out_Data), 32'(exp));
    chk({nm, "_ch"}, 32'(bus.Out_Ch), 32'(ch));
    tick();
    chk({nm, "_drain"}, 32'(bus.Out_Valid), 0);
    In_TransmitOnb[ch] = 1'b1;
    In_Doutb = '1;
    repeat (6) tick();
  endtask
  initial begin
    vec_t vt [5];
    int fe;
    logic v;
    vt[0] = '{1'b0, 16'h3007, 16'h3005};
    vt[1] = '{1'b0, 16'hFFFF, 16'hFAAA};
    vt[2] = '{1'b1, 16'h0800, 16'h0FFF};
    vt[3] = '{1'b0, 16'hA000, 16'hA000};
    vt[4] = '{1'b1, 16'h0C00, 16'h0800};
    bus.In_Ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.Out_Valid), 0);
    chk("rst_data", 32'(bus.Out_Data), 0);
    chk("rst_ch", 32'(bus.Out_Ch), 0);
    chk("rst_ovf", 32'(Overflow), 0);
    chk("rst_fe", 32'(Frame_End), 0);
    chk("rst_rt", 32'(Reach_Thresh), 0);
    Rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) xfer(vt[i].ch, vt[i].raw, vt[i].exp, $sformatf("vec%0d", i));
    In_TransmitOnb = 2'b00;
    send(2'b11, 16'h0001, 16'h0002, 16);
    tick();
    chk("pair1_early", 32'(bus.Out_Valid), 0);
    tick();
    chk("pair1_a_data", 32'(bus.Out_Data), 32'h0001);
    chk("pair1_a_ch", 32'(bus.Out_Ch), 0);
    tick();
    chk("pair1_b_data", 32'(bus.Out_Data), 32'h0003);
    chk("pair1_b_ch", 32'(bus.Out_Ch), 1);
    tick();
    chk("pair1_drain", 32'(bus.Out_Valid), 0);
    In_TransmitOnb = 2'b11;
    In_Doutb = '1;
    repeat (6) tick();
    In_TransmitOnb = 2'b00;
    send(2'b11, 16'h8000, 16'h0003, 16);
    repeat (2) tick();
    chk("pair2_a_data", 32'(bus.Out_Data), 32'h8000);
    chk("pair2_a_ch", 32'(bus.Out_Ch), 0);
    tick();
    chk("pair2_b_data", 32'(bus.Out_Data), 32'h0002);
    chk("pair2_b_ch", 32'(bus.Out_Ch), 1);
    chk("pair2_rt", 32'(Reach_Thresh), 0);
    In_TransmitOnb = 2'b11;
    In_Doutb = '1;
    repeat (6) tick();
    bus.In_Ready = 1'b0;
    In_TransmitOnb[0] = 1'b0;
    send(2'b01, 16'h1000, 16'h0, 16);
    send(2'b01, 16'h2000, 16'h0, 16);
    send(2'b01, 16'h3001, 16'h0, 16);
    send(2'b01, 16'h4000, 16'h0, 16);
    repeat (2) tick();
    chk("ovf_set", 32'(Overflow), 32'h1);
    chk("hold_valid", 32'(bus.Out_Valid), 1);
    chk("hold_data", 32'(bus.Out_Data), 32'h1000);
    chk("four_words_rt", 32'(Reach_Thresh[0]), 1);
    In_TransmitOnb[0] = 1'b1;
    In_Doutb = '1;
    repeat (6) tick();
    chk("hold_data_late", 32'(bus.Out_Data), 32'h1000);
    bus.In_Ready = 1'b1;
    tick();
    chk("drain_b", 32'(bus.Out_Data), 32'h2000);
    tick();
    chk("drain_c", 32'(bus.Out_Data), 32'h3001);
    chk("drain_c_valid", 32'(bus.Out_Valid), 1);
    tick();
    chk("drain_empty", 32'(bus.Out_Valid), 0);
    chk("ovf_sticky", 32'(Overflow), 32'h1);
    In_TransmitOnb[0] = 1'b0;
    send(2'b01, 16'hFFFF, 16'h0, 7);
    In_TransmitOnb[0] = 1'b1;
    In_Doutb = '1;
    fe = 0;
    v = 1'b0;
    repeat (12) begin
      tick();
      fe += int'(Frame_End[0]);
      v |= bus.Out_Valid;
    end
    chk("partial_fe_cycles", 32'(fe), 1);
    chk("partial_no_valid", 32'(v), 0);
    chk("partial_rt_cleared", 32'(Reach_Thresh[0]), 0);
    xfer(1'b0, 16'h0007, 16'h0005, "after_partial");
    In_TransmitOnb[1] = 1'b0;
    send(2'b10, 16'h0, 16'h0100, 16);
    send(2'b10, 16'h0, 16'h0200, 16);
    chk("thr_two", 32'(Reach_Thresh[1]), 0);
    send(2'b10, 16'h0, 16'h0300, 16);
    chk("thr_three", 32'(Reach_Thresh[1]), 1);
    In_TransmitOnb[1] = 1'b1;
    In_Doutb = '1;
    repeat (8) tick();
    chk("thr_hold", 32'(Reach_Thresh[1]), 1);
    In_TransmitOnb[1] = 1'b0;
    repeat (4) tick();
    chk("thr_clear", 32'(Reach_Thresh[1]), 0);
    In_TransmitOnb[1] = 1'b1;
    repeat (6) tick();
    bus.In_Ready = 1'b0;
    In_TransmitOnb[0] = 1'b0;
    send(2'b01, 16'h1234, 16'h0, 16);
    repeat (2) tick();
    chk("pre_rst_valid", 32'(bus.Out_Valid), 1);
    chk("pre_rst_data", 32'(bus.Out_Data), 32'h13D8);
    chk("pre_rst_ovf", 32'(Overflow), 32'h1);
    send(2'b01, 16'h5555, 16'h0, 5);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("midrst_valid", 32'(bus.Out_Valid), 0);
    chk("midrst_data", 32'(bus.Out_Data), 0);
    chk("midrst_ovf", 32'(Overflow), 0);
    chk("midrst_rt", 32'(Reach_Thresh), 0);
    chk("midrst_fe", 32'(Frame_End), 0);
    In_TransmitOnb[0] = 1'b1;
    In_Doutb = '1;
    bus.In_Ready = 1'b1;
    repeat (6) tick();
    xfer(1'b0, 16'h0003, 16'h0002, "post_rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/readout_dout_multi.md
Name: readout_dout_multi

Overview:
Multi-channel successor to the single-line Doutb deserializer. It takes NUM_CH active-low serial Doutb lines, each gated by its own active-low TransmitOnb. Each line is deserialised into WORD_W-bit words, and the low GRAY_W bits are converted from Gray to binary. Words are buffered per channel and merged round-robin onto one valid/ready stream toward the DIF readout FIFO. Per-channel word counting, threshold flags, frame-end pulses and sticky overflow flags are also provided.

Parameters:
NUM_CH, 2, number of serial Doutb channels (1..8)
WORD_W, 16, bits per serial word, MSB first
GRAY_W, 12, low bits Gray-coded (GRAY_W <= WORD_W); upper bits pass through unchanged
DIV, 4, Clk cycles per serial bit (slow clock = Clk/DIV, DIV >= 2)
SAMPLE_PHASE, 1, phase-counter value at which a bit is sampled (0..DIV-1)
THRESH, 1580, word count at which Reach_Thresh asserts
CNT_W, 16, word counter width

Ports:
Clk  in  1  system clock, 40 MHz
Rst  in  1  synchronous reset, active-high
In_Doutb  in  NUM_CH  serial data, active-low, asynchronous
In_TransmitOnb  in  NUM_CH  frame gate, low while transmitting, asynchronous
Out_Data  out  WORD_W  converted word
Out_Ch  out  max(1,clog2(NUM_CH))  source channel of Out_Data
Out_Valid  out  1  Out_Data/Out_Ch valid
In_Ready  in  1  downstream accepts when Out_Valid && In_Ready
Reach_Thresh  out  NUM_CH  word count >= THRESH
Frame_End  out  NUM_CH  one-cycle pulse on TransmitOnb rising edge
Overflow  out  NUM_CH  sticky: word dropped because buffer full

Behaviour:
- Single clock domain. All reset is synchronous on Rst.
- Reset values:
  - Out_Data=0, Out_Ch=0, Out_Valid=0, Frame_End=0, Overflow=0.
  - Word counters=0, so Reach_Thresh=0 unless THRESH=0.
  - Sync registers=1 (idle), phase/bit counters=0, buffers empty, round-robin pointer=0.
- Input sync: each In_Doutb and In_TransmitOnb bit goes through a 2-flop synchroniser. Everything below uses the 2nd stage (tx_s, dout_s).
- Per channel, while tx_s=1: phase counter and bit counter are held at 0 and the shift register is cleared.
- Per channel, while tx_s=0: phase counter increments modulo DIV.
  - When phase==SAMPLE_PHASE: shift in ~dout_s, MSB first; bit counter increments.
  - Bit counter wraps at WORD_W-1.
- Word complete = sample cycle with bit counter==WORD_W-1.
  - Next cycle: push {raw[WORD_W-1:GRAY_W], gray2bin(raw[GRAY_W-1:0])} into the channel buffer.
  - gray2bin: b[GRAY_W-1]=g[GRAY_W-1]; b[i]=b[i+1]^g[i].
- Partial word at TransmitOnb rising edge: discarded, no push.
  - Frame_End[ch] pulses for one cycle on the tx_s 0->1 transition.
- Word counter:
  - Cleared on the tx_s 1->0 transition (frame start).
  - +1 per completed word, including dropped words.
  - Saturates at all-ones.
  - Holds after frame end so it stays readable.
  - Reach_Thresh = (cnt >= THRESH), combinational from the counter.
- Channel buffer: 2-entry FIFO.
  - Push while full: the new word is dropped, the FIFO is unchanged, and Overflow[ch] is set. It clears only on Rst.
  - Push and pop in the same cycle while full: legal, no overflow.
- Output register: loadable when Out_Valid=0 or (Out_Valid && In_Ready).
  - Arbiter grants the first non-empty channel, searching upward from pointer+1 (wrapping).
  - On grant: pop that FIFO, load Out_Data/Out_Ch, set Out_Valid=1, pointer <= granted channel.
  - No grant candidates and current word accepted: Out_Valid=0.
  - Throughput: 1 word/cycle.
- Out_Data and Out_Ch are stable while Out_Valid && !In_Ready.
- Latency: last-bit sample cycle N -> FIFO entry at N+1 -> Out_Valid at N+2, given the output register is free and the channel wins arbitration.
- Rst mid-word or mid-handshake: all state returns to reset values the next cycle; pending words are lost.

Test Plan:
1. NUM_CH=2 defaults. Ch0 drives raw (inverted-line) word 16'h3007 at DIV=4, ch1 idle, In_Ready=1 -> one beat Out_Data=16'h3005, Out_Ch=0, at last-sample+2 cycles. Word count=1, Reach_Thresh=0.
2. Both channels complete words (16'h0001 on ch0, 16'h0002 on ch1) in the same cycle -> Out_Data=16'h0001 / Out_Ch=0, then 16'h0003 / Out_Ch=1 on consecutive cycles. Next simultaneous pair is served ch0 first again (pointer was 1).
3. In_Ready=0, ch0 sends 4 words A,B,C,D -> A held in the output register, B and C buffered, D dropped, Overflow[0]=1. Raise In_Ready -> A,B,C emitted in order; Overflow stays 1 until Rst.
4. Ch0 TransmitOnb rises after 7 sampled bits -> no Out_Valid, Frame_End[0] pulses exactly 1 cycle. Next frame of 16 bits yields a correct word.
5. THRESH=3: ch1 frame with 3 words -> Reach_Thresh[1] asserts the cycle after the 3rd word completes and holds after frame end. The next TransmitOnb falling edge clears it.
6. Rst asserted for 1 cycle mid-word with Out_Valid=1 and In_Ready=0 -> next cycle Out_Valid=0, Overflow=0, counters=0. Subsequent full word decodes correctly.
